// File: rtl/remote_comm.sv
// remote_comm: full-duplex UART command bridge.
// Transmit path sends a 16-bit command as two 8N1 frames, high byte first.
// Receive path captures 8N1 response bytes and strobes resp_rdy.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} tx_state_t;

    tx_state_t   r_state;
    tx_state_t   w_next;
    logic [7:0]  r_cmd_lo;
    logic        r_cmd_snt;
    logic        w_latch;
    logic        w_set_snt;
    logic        w_tx_load;
    logic [7:0]  w_tx_byte;
    logic        w_tx_done;

    logic [9:0]  r_tx_shift;
    logic [11:0] r_tx_baud;
    logic [3:0]  r_tx_bit;
    logic        r_tx_busy;

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic        w_rx_fall;
    logic        r_rx_busy;
    logic [11:0] r_rx_baud;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_resp;
    logic        r_resp_rdy;

    // Stop-bit interval of the current frame has just elapsed.
    assign w_tx_done = r_tx_busy && (r_tx_baud == 12'd0) && (r_tx_bit == 4'd9);

    // Transmit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Transmit FSM next-state and byte-load decisions.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        w_next    = r_state;
        w_latch   = 1'b0;
        w_set_snt = 1'b0;
        w_tx_load = 1'b0;
        w_tx_byte = r_cmd_lo;
        case (r_state)
            IDLE: begin
                if (snd_cmd) begin
                    w_latch   = 1'b1;
                    w_tx_load = 1'b1;
                    w_tx_byte = cmd[15:8];
                    w_next    = SEND_HI;
                end
            end
            SEND_HI: begin
                if (w_tx_done) begin
                    w_tx_load = 1'b1;
                    w_tx_byte = r_cmd_lo;
                    w_next    = SEND_LO;
                end
            end
            SEND_LO: begin
                if (w_tx_done) begin
                    w_set_snt = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Low-byte latch and completion flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_lo  <= 8'h00;
            r_cmd_snt <= 1'b0;
        end else if (w_latch) begin
            r_cmd_lo  <= cmd[7:0];
            r_cmd_snt <= 1'b0;
        end else if (w_set_snt) begin
            r_cmd_snt <= 1'b1;
        end
    end

    // UART transmitter: 10-bit frame shifted out LSB first, one bit per BAUD_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '1;
            r_tx_baud  <= 12'd0;
            r_tx_bit   <= 4'd0;
            r_tx_busy  <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
            r_tx_baud  <= BAUD_LAST;
            r_tx_bit   <= 4'd0;
            r_tx_busy  <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_baud == 12'd0) begin
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                    r_tx_baud  <= BAUD_LAST;
                end
            end else begin
                r_tx_baud <= r_tx_baud - 12'd1;
            end
        end
    end

    // Two-flop synchroniser plus one history flop for start-edge detection, all preset high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // UART receiver: sample at bit centres; slot 0 is start, 1..8 data, 9 stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_busy  <= 1'b0;
            r_rx_baud  <= 12'd0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= 8'h00;
            r_resp     <= 8'h00;
            r_resp_rdy <= 1'b0;
        end else begin
            r_resp_rdy <= 1'b0;
            if (!r_rx_busy) begin
                if (w_rx_fall) begin
                    r_rx_busy <= 1'b1;
                    r_rx_baud <= HALF_LAST;
                    r_rx_bit  <= 4'd0;
                end
            end else if (r_rx_baud == 12'd0) begin
                r_rx_baud <= BAUD_LAST;
                if (r_rx_bit == 4'd9) begin
                    r_resp     <= r_rx_shift;
                    r_resp_rdy <= 1'b1;
                    r_rx_busy  <= 1'b0;
                end else begin
                    if (r_rx_bit != 4'd0) r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bit <= r_rx_bit + 4'd1;
                end
            end else begin
                r_rx_baud <= r_rx_baud - 12'd1;
            end
        end
    end

    assign TX       = r_tx_shift[0];
    assign cmd_snt  = r_cmd_snt;
    assign resp     = r_resp;
    assign resp_rdy = r_resp_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// Testbench for remote_comm: table vectors, randomized commands/responses, corner sequences.
module tb_remote_comm;

    localparam int B = 16;

    logic        clk;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int rdy_cnt = 0;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latencies can be measured in clocks.
    always @(posedge clk) cyc <= cyc + 1;

    // Count resp_rdy cycles; a stretched pulse counts more than once.
    always @(negedge clk) if (resp_rdy === 1'b1) rdy_cnt <= rdy_cnt + 1;

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // UART model driving RX with one 8N1 frame.
    task automatic drive_rx(input logic [7:0] b);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    // UART model decoding one 8N1 frame from TX, sampling at bit centres.
    task automatic decode_tx(output logic [7:0] b, output bit ok);
        int n = 0;
        bit start_ok;
        b  = 8'h00;
        ok = 1'b0;
        while (TX !== 1'b0 && n < 6 * B) begin
            @(negedge clk);
            n++;
        end
        if (TX !== 1'b0) return;
        repeat (B / 2) @(negedge clk);
        start_ok = (TX === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            b[i] = TX;
        end
        repeat (B) @(negedge clk);
        ok = start_ok && (TX === 1'b1);
    endtask

    // One-cycle snd_cmd pulse; t0 is the number of the sampling edge.
    task automatic pulse_cmd(input logic [15:0] c, output int t0);
        @(negedge clk);
        cmd     = c;
        snd_cmd = 1'b1;
        t0      = cyc + 1;
        @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    // Wait (bounded) for cmd_snt and check its latency from the sampling edge.
    task automatic wait_snt(input int t0);
        int n = 0;
        while (cmd_snt !== 1'b1 && n < 30 * B) begin
            @(negedge clk);
            n++;
        end
        if (cmd_snt !== 1'b1) check("cmd_snt_timeout", 32'(cmd_snt), 32'd1);
        else check_range("cmd_snt_latency", cyc - t0, 20 * B, 20 * B + 2);
    endtask

    // Full command send with an optional concurrent response byte on RX.
    task automatic run_txn(input logic [15:0] c, input logic [7:0] rxb, input logic do_rx,
                           input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                           input logic [7:0] exp_resp);
        int         r0 = rdy_cnt;
        int         t0;
        logic [7:0] hi, lo;
        bit         ok_hi, ok_lo;
        fork
            begin
                pulse_cmd(c, t0);
                check("cmd_snt_cleared", 32'(cmd_snt), 32'd0);
                wait_snt(t0);
            end
            begin
                decode_tx(hi, ok_hi);
                decode_tx(lo, ok_lo);
            end
            begin
                if (do_rx) begin
                    repeat (2) @(negedge clk);
                    drive_rx(rxb);
                end
            end
        join
        repeat (4) @(negedge clk);
        check("tx_hi_byte", {23'd0, ok_hi, hi}, {23'd0, 1'b1, exp_hi});
        check("tx_lo_byte", {23'd0, ok_lo, lo}, {23'd0, 1'b1, exp_lo});
        check("resp_rdy_count", rdy_cnt - r0, do_rx ? 32'd1 : 32'd0);
        check("resp_value", 32'(resp), 32'(exp_resp));
    endtask

    typedef struct packed {
        logic [15:0] cmd;
        logic [7:0]  rx_byte;
        logic        do_rx;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_resp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0]  model_resp;
        logic [15:0] c;
        logic [7:0]  rxb;
        logic        dorx;
        logic [7:0]  b0, b1, b2, b3;
        bit          k0, k1, k2, k3;
        bit          quiet;
        int          t0, t1, r0;

        vecs[0] = '{16'h2000, 8'h00, 1'b0, 8'h20, 8'h00, 8'h00};
        vecs[1] = '{16'h4002, 8'hA5, 1'b1, 8'h40, 8'h02, 8'hA5};
        vecs[2] = '{16'hFFFF, 8'h5A, 1'b1, 8'hFF, 8'hFF, 8'h5A};
        vecs[3] = '{16'h0001, 8'h00, 1'b0, 8'h00, 8'h01, 8'h5A};
        vecs[4] = '{16'h8180, 8'hFF, 1'b1, 8'h81, 8'h80, 8'hFF};
        vecs[5] = '{16'h55AA, 8'h00, 1'b1, 8'h55, 8'hAA, 8'h00};

        rst = 1'b1; RX = 1'b1; cmd = 16'h0000; snd_cmd = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_cmd_snt", 32'(cmd_snt), 32'd0);
        check("reset_resp_rdy", 32'(resp_rdy), 32'd0);
        check("reset_resp", 32'(resp), 32'h00);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (2 * B) begin
            @(negedge clk);
            if (TX !== 1'b1) quiet = 1'b0;
        end
        check("idle_tx_high", 32'(quiet), 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].cmd, vecs[i].rx_byte, vecs[i].do_rx,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_resp);
        end
        model_resp = vecs[5].exp_resp;

        // Randomized commands against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            c    = 16'($urandom_range(0, 65535));
            rxb  = 8'($urandom_range(0, 255));
            dorx = 1'($urandom_range(0, 1));
            if (dorx) model_resp = rxb;
            run_txn(c, rxb, dorx, 8'(c / 256), 8'(c % 256), model_resp);
        end

        // snd_cmd during a transmission is ignored; cmd changes after the latch have no effect.
        fork
            begin
                pulse_cmd(16'h4022, t0);
                wait_snt(t0);
            end
            begin
                decode_tx(b0, k0);
                decode_tx(b1, k1);
            end
            begin
                repeat (5 * B) @(negedge clk);
                cmd = 16'h43F1; snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
                repeat (8 * B) @(negedge clk);
                snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
            end
        join
        check("ignore_hi", {23'd0, k0, b0}, {23'd0, 1'b1, 8'h40});
        check("ignore_lo", {23'd0, k1, b1}, {23'd0, 1'b1, 8'h22});
        quiet = 1'b1;
        repeat (3 * B) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_snt !== 1'b1) quiet = 1'b0;
        end
        check("ignore_no_extra_frame", 32'(quiet), 32'd1);
        run_txn(16'h43F1, 8'h00, 1'b0, 8'h43, 8'hF1, model_resp);

        // snd_cmd held as a level: next command accepted the cycle after cmd_snt sets.
        fork
            begin
                @(negedge clk);
                cmd = 16'h1357; snd_cmd = 1'b1; t0 = cyc + 1;
                @(negedge clk);
                cmd = 16'h2468;
                wait_snt(t0);
                t1 = cyc + 1;
                @(negedge clk);
                check("b2b_snt_one_cycle", 32'(cmd_snt), 32'd0);
                snd_cmd = 1'b0;
                wait_snt(t1);
            end
            begin
                decode_tx(b0, k0);
                decode_tx(b1, k1);
                decode_tx(b2, k2);
                decode_tx(b3, k3);
            end
        join
        check("b2b_byte0", {23'd0, k0, b0}, {23'd0, 1'b1, 8'h13});
        check("b2b_byte1", {23'd0, k1, b1}, {23'd0, 1'b1, 8'h57});
        check("b2b_byte2", {23'd0, k2, b2}, {23'd0, 1'b1, 8'h24});
        check("b2b_byte3", {23'd0, k3, b3}, {23'd0, 1'b1, 8'h68});

        // Reset in the middle of the high byte and of a receive frame.
        pulse_cmd(16'h00FF, t0);
        RX = 1'b0;
        repeat (4 * B) @(negedge clk);
        check("pre_reset_tx_low", 32'(TX), 32'd0);
        r0 = rdy_cnt;
        rst = 1'b1;
        #1;
        check("reset_async_tx", 32'(TX), 32'd1);
        check("reset_mid_cmd_snt", 32'(cmd_snt), 32'd0);
        repeat (2) @(negedge clk);
        RX = 1'b1;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (12 * B) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_snt !== 1'b0) quiet = 1'b0;
        end
        check("reset_abort_quiet", 32'(quiet), 32'd1);
        check("reset_no_resp_rdy", rdy_cnt - r0, 32'd0);
        check("reset_resp_cleared", 32'(resp), 32'h00);
        run_txn(16'h9C3E, 8'h3C, 1'b1, 8'h9C, 8'h3E, 8'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
